// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared typedefs and helpers for the pipeline blocks.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

  // Serializer control states: waiting for a word, or emitting its beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A valid/ready pair as seen on one side of a pipeline stage.
  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  // Map a beat ordinal to the word slice it comes from. Beat 0 is the
  // least-significant slice unless msb_first is set, in which case the order
  // is reversed.
  function automatic int unsigned beat_index(
    input int unsigned cnt,
    input int unsigned num_beats,
    input bit          msb_first
  );
    return msb_first ? (num_beats - 1 - cnt) : cnt;
  endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipe_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_serializer_if
//  Purpose  : Wide-word input and narrow-beat output handshakes of the
//             serializer, bundled so the block and its neighbours share
//             one port list.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_serializer_if #(
  parameter int IN_WIDTH   = 32,
  parameter int BEAT_WIDTH = 8
);

  logic [IN_WIDTH-1:0]   prev_data;
  logic                  prev_valid;
  logic                  prev_ready;
  logic [BEAT_WIDTH-1:0] next_data;
  logic                  next_valid;
  logic                  next_last;
  logic                  next_ready;

  // Environment view: supplies words and consumes beats.
  modport master (
    output prev_data,
    output prev_valid,
    input  prev_ready,
    input  next_data,
    input  next_valid,
    input  next_last,
    output next_ready
  );

  // Serializer view: consumes words and supplies beats.
  modport slave (
    input  prev_data,
    input  prev_valid,
    output prev_ready,
    output next_data,
    output next_valid,
    output next_last,
    input  next_ready
  );

endinterface : pipe_serializer_if
`default_nettype wire

// File: rtl/pipe_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_serializer
//  Purpose  : Accepts IN_WIDTH-bit words and emits them as NUM_BEATS
//             BEAT_WIDTH-bit beats, LSB- or MSB-slice first, with gapless
//             back-to-back words when upstream keeps up.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_serializer
  import pipeline_pkg::*;
#(
  parameter int IN_WIDTH      = 32,
  parameter int BEAT_WIDTH    = 8,
  parameter bit OPT_MSB_FIRST = 1'b0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            clear,
  pipe_serializer_if.slave     bus
);

  localparam int unsigned NUM_BEATS = IN_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(NUM_BEATS - 1);

  // Only whole-beat words of at least two beats make sense here.
  generate
    if ((IN_WIDTH % BEAT_WIDTH) != 0 || NUM_BEATS < 2) begin : g_param_check
      $error("pipe_serializer: IN_WIDTH must be a multiple of BEAT_WIDTH with at least two beats");
    end
  endgenerate

  ser_state_t          r_state;
  ser_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    w_beat_cnt_nxt;
  logic [IN_WIDTH-1:0] r_word;
  logic [IN_WIDTH-1:0] w_word_nxt;

  logic                w_on_last;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_prev_ready;
  int unsigned         w_slice;

  // Handshake qualifiers and the selected beat; reset and clear both
  // block acceptance so no word can slip in while the block is flushing.
  always_comb begin
    w_on_last    = (r_state == SEND) && (r_beat_cnt == c_last_beat);
    w_prev_ready = !rst && !clear &&
                   ((r_state == IDLE) || (w_on_last && bus.next_ready));
    w_in_xfer    = bus.prev_valid && w_prev_ready;
    w_out_xfer   = (r_state == SEND) && bus.next_ready;
    w_slice      = beat_index(32'(r_beat_cnt), NUM_BEATS, OPT_MSB_FIRST);
  end

  assign bus.prev_ready = w_prev_ready;
  assign bus.next_valid = (r_state == SEND);
  assign bus.next_last  = w_on_last;
  assign bus.next_data  = r_word[w_slice*BEAT_WIDTH +: BEAT_WIDTH];

  // Next-state logic: clear wins, then load/advance/reload on transfers.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_word_nxt     = r_word;
    if (clear) begin
      w_state_nxt    = IDLE;
      w_beat_cnt_nxt = '0;
      w_word_nxt     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            w_state_nxt    = SEND;
            w_beat_cnt_nxt = '0;
            w_word_nxt     = bus.prev_data;
          end
        end
        SEND: begin
          if (w_out_xfer) begin
            if (w_on_last) begin
              w_beat_cnt_nxt = '0;
              if (w_in_xfer) begin
                // Reload on the last beat keeps the output stream gapless.
                w_state_nxt = SEND;
                w_word_nxt  = bus.prev_data;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_beat_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, beat counter and word register; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_word     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_word     <= w_word_nxt;
    end
  end

endmodule : pipe_serializer
`default_nettype wire

// File: tb/tb_pipe_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_serializer
//  Purpose  : Directed self-checking bench for pipe_serializer, with an
//             LSB-first and an MSB-first instance fed identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_serializer_if #(.IN_WIDTH(32), .BEAT_WIDTH(8)) bus_lsb ();
  pipe_serializer_if #(.IN_WIDTH(32), .BEAT_WIDTH(8)) bus_msb ();

  pipe_serializer #(.IN_WIDTH(32), .BEAT_WIDTH(8), .OPT_MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus_lsb)
  );

  pipe_serializer #(.IN_WIDTH(32), .BEAT_WIDTH(8), .OPT_MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus_msb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pd, input logic nr);
    bus_lsb.prev_valid = pv;
    bus_lsb.prev_data  = pd;
    bus_lsb.next_ready = nr;
    bus_msb.prev_valid = pv;
    bus_msb.prev_data  = pd;
    bus_msb.next_ready = nr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq_a [4];
    logic [7:0] seq_b [8];
    logic [7:0] seq_m [4];
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    seq_m = '{8'h44, 8'h33, 8'h22, 8'h11};

    drive(1'b0, 32'h0, 1'b0);

    // Reset state.
    tick();
    tick();
    check("rst_valid", 32'(bus_lsb.next_valid), 32'd0);
    check("rst_pready", 32'(bus_lsb.prev_ready), 32'd0);
    check("rst_data", 32'(bus_lsb.next_data), 32'd0);
    check("rst_last", 32'(bus_lsb.next_last), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_pready", 32'(bus_lsb.prev_ready), 32'd1);
    check("post_rst_valid", 32'(bus_lsb.next_valid), 32'd0);
    tick();
    check("idle_valid", 32'(bus_lsb.next_valid), 32'd0);

    // Basic word, downstream always ready.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_data%0d", i), 32'(bus_lsb.next_data), 32'(seq_a[i]));
      check($sformatf("basic_valid%0d", i), 32'(bus_lsb.next_valid), 32'd1);
      check($sformatf("basic_last%0d", i), 32'(bus_lsb.next_last), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("basic_done_valid", 32'(bus_lsb.next_valid), 32'd0);
    check("basic_done_pready", 32'(bus_lsb.prev_ready), 32'd1);

    // Backpressure while 0x33 is presented.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_data%0d", i), 32'(bus_lsb.next_data), 32'h33);
      check($sformatf("stall_valid%0d", i), 32'(bus_lsb.next_valid), 32'd1);
      check($sformatf("stall_last%0d", i), 32'(bus_lsb.next_last), 32'd0);
      check($sformatf("stall_pready%0d", i), 32'(bus_lsb.prev_ready), 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    check("stall_release_data", 32'(bus_lsb.next_data), 32'h33);
    tick();
    check("stall_next_data", 32'(bus_lsb.next_data), 32'h44);
    check("stall_next_last", 32'(bus_lsb.next_last), 32'd1);
    tick();
    check("stall_done_valid", 32'(bus_lsb.next_valid), 32'd0);

    // Back-to-back words with prev_valid held.
    drive(1'b1, 32'hDDCCBBAA, 1'b1);
    check("b2b_idle_pready", 32'(bus_lsb.prev_ready), 32'd1);
    tick();
    drive(1'b1, 32'h04030201, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_data%0d", k), 32'(bus_lsb.next_data), 32'(seq_b[k]));
      check($sformatf("b2b_valid%0d", k), 32'(bus_lsb.next_valid), 32'd1);
      check($sformatf("b2b_pready%0d", k), 32'(bus_lsb.prev_ready),
            (k == 3 || k == 7) ? 32'd1 : 32'd0);
      check($sformatf("b2b_last%0d", k), 32'(bus_lsb.next_last),
            (k == 3 || k == 7) ? 32'd1 : 32'd0);
      tick();
      if (k == 3) drive(1'b0, 32'h0, 1'b1);
    end
    check("b2b_done_valid", 32'(bus_lsb.next_valid), 32'd0);

    // MSB-first ordering on the second instance.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("msb_data%0d", i), 32'(bus_msb.next_data), 32'(seq_m[i]));
      check($sformatf("msb_last%0d", i), 32'(bus_msb.next_last), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("msb_done_valid", 32'(bus_msb.next_valid), 32'd0);

    // Clear after 0x22 has transferred.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    check("clr_pre_data", 32'(bus_lsb.next_data), 32'h33);
    clear = 1'b1;
    #1;
    check("clr_pready_low", 32'(bus_lsb.prev_ready), 32'd0);
    tick();
    clear = 1'b0;
    #1;
    check("clr_valid", 32'(bus_lsb.next_valid), 32'd0);
    check("clr_pready", 32'(bus_lsb.prev_ready), 32'd1);
    drive(1'b1, 32'h88776655, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    check("clr_new_first", 32'(bus_lsb.next_data), 32'h55);
    check("clr_new_valid", 32'(bus_lsb.next_valid), 32'd1);
    tick();
    tick();
    tick();
    check("clr_new_lastdata", 32'(bus_lsb.next_data), 32'h88);
    check("clr_new_last", 32'(bus_lsb.next_last), 32'd1);
    tick();

    // Asynchronous reset in the middle of a word.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("arst_pre_data", 32'(bus_lsb.next_data), 32'h22);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus_lsb.next_valid), 32'd0);
    check("arst_pready", 32'(bus_lsb.prev_ready), 32'd0);
    check("arst_data", 32'(bus_lsb.next_data), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_rel_pready", 32'(bus_lsb.prev_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arst_no_replay%0d", i), 32'(bus_lsb.next_valid), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_serializer
`default_nettype wire

// File: doc/pipe_serializer.md
PIPE_SERIALIZER -- requirements
Module: pipe_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width in bits of one accepted input word.
REQ-002 SHALL have parameter BEAT_WIDTH, default 8, width in bits of one emitted output beat.
REQ-003 SHALL have parameter OPT_MSB_FIRST, default 1'b0, which selects the most-significant beat first when set.
REQ-004 SHALL have derived constant NUM_BEATS = IN_WIDTH/BEAT_WIDTH, the number of beats per word.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst, input, 1 bit, reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clear, input, 1 bit, synchronous flush of the word in flight.
REQ-008 SHALL have port prev_data, input, IN_WIDTH bits, the wide input word.
REQ-009 SHALL have port prev_valid, input, 1 bit, which marks prev_data as valid.
REQ-010 SHALL have port prev_ready, output, 1 bit, which signals the block accepts a word this cycle.
REQ-011 SHALL have port next_data, output, BEAT_WIDTH bits, the current output beat.
REQ-012 SHALL have port next_valid, output, 1 bit, which marks next_data as valid.
REQ-013 SHALL have port next_last, output, 1 bit, which marks the final beat of a word.
REQ-014 SHALL have port next_ready, input, 1 bit, downstream acceptance of a beat.

Function
REQ-015 SHALL support IN_WIDTH % BEAT_WIDTH == 0 and NUM_BEATS >= 2 only; other values are a static elaboration error.
REQ-016 SHALL treat a transfer on either side as occurring when valid && ready are both high at a clk rising edge.
REQ-017 SHALL implement states IDLE and SEND, using a word register and a beat counter of width $clog2(NUM_BEATS).
REQ-018 SHALL drive prev_ready = (state==IDLE) || (state==SEND && beat_cnt==NUM_BEATS-1 && next_ready) while rst and clear are low, and drive it low otherwise.
REQ-019 SHALL, on an input transfer, load the word register, set beat_cnt to 0 and enter SEND, so beat 0 appears one cycle after the accept.
REQ-020 SHALL drive next_valid high exactly when state==SEND.
REQ-021 SHALL select next_data as word slice beat_cnt, counted from the LSB when OPT_MSB_FIRST is low and from the MSB when it is high.
REQ-022 SHALL drive next_last = (state==SEND && beat_cnt==NUM_BEATS-1).
REQ-023 SHALL, while next_valid && !next_ready, hold next_data, next_last and beat_cnt stable.
REQ-024 SHALL increment beat_cnt by 1 on each output transfer that is not the last beat.
REQ-025 SHALL, on the output transfer of the last beat, enter IDLE if no input transfer occurs in the same cycle.
REQ-026 SHALL, on the output transfer of the last beat with a simultaneous input transfer, reload the word, reset beat_cnt to 0 and stay in SEND, giving gapless back-to-back words at 1 beat per cycle.
REQ-027 SHALL, when clear is high at a clk edge, force IDLE and beat_cnt=0 and discard the word in flight, with clear taking priority over all transfers.

Reset
REQ-028 SHALL, while rst is high, asynchronously force state=IDLE, beat_cnt=0, word register=0, next_valid=0, next_last=0, next_data=0 and prev_ready=0.
REQ-029 SHALL, after rst deasserts, drive prev_ready high in the first cycle, with no beats emitted until a word is accepted.
REQ-030 SHALL, on a reset asserted mid-word, drop the remaining beats and not replay them.

Structure
REQ-031 SHALL place the state enum type (IDLE, SEND) in shared package pipeline_pkg alongside the other pipeline typedefs.
REQ-032 SHALL be a single flat module with no sub-module, because the counter and shifter are too small to justify one.

Verification
REQ-033 SHALL cover: accept 0x44332211 with next_ready=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, next_last only with 0x44.
REQ-034 SHALL cover: next_ready low for 3 cycles while 0x33 is presented -> next_data=0x33, next_valid=1 and next_last=0 held stable, then 0x44 follows.
REQ-035 SHALL cover: prev_valid held with words 0xDDCCBBAA then 0x04030201 -> 8 contiguous beats AA,BB,CC,DD,01,02,03,04 with prev_ready high only in the IDLE accept cycle and the last-beat cycle.
REQ-036 SHALL cover: OPT_MSB_FIRST=1 and accept 0x44332211 -> beats 0x44,0x33,0x22,0x11.
REQ-037 SHALL cover: clear pulsed after beat 0x22 transfers -> next_valid=0 the next cycle, prev_ready=1, and the next word starts at its beat 0.
REQ-038 SHALL cover: rst asserted asynchronously mid-word -> next_valid and prev_ready drop immediately, and no remaining beats appear after release.
